// File: rtl/led_pkg.sv
// Shared encodings and constants for the LED sequencer: FSM states, pattern
// codes, bounce direction and pattern start values.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_COUNT  = 2'd0,
        PAT_ROTATE = 2'd1,
        PAT_BOUNCE = 2'd2
    } pattern_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int unsigned LED_W        = 10;
    localparam logic [9:0]  START_COUNT  = 10'h000;
    localparam logic [9:0]  START_ONEHOT = 10'h001;

    function automatic pattern_t next_pattern(input pattern_t p);
        pattern_t n;
        case (p)
            PAT_COUNT:  n = PAT_ROTATE;
            PAT_ROTATE: n = PAT_BOUNCE;
            default:    n = PAT_COUNT;
        endcase
        return n;
    endfunction

    function automatic logic [9:0] pattern_start(input pattern_t p);
        return (p == PAT_COUNT) ? START_COUNT : START_ONEHOT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, counter debounce and
// a one-cycle press pulse on each accepted 1->0 transition.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic [1:0]  sync_ff;
    logic        sync;
    logic        level;
    logic [15:0] cnt;
    logic [1:0]  fill;
    logic        armed;

    assign sync = sync_ff[1];

    // Presses stay disarmed after reset until the real button has been seen
    // released, so a button held through reset release never fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_ff <= '1;
            level   <= 1'b1;
            cnt     <= '0;
            fill    <= '0;
            armed   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], btn};
            press   <= 1'b0;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (fill == 2'd2 && sync)
                armed <= 1'b1;
            if (sync != level) begin
                if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    level <= sync;
                    cnt   <= '0;
                    press <= armed & ~sync;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: run/pause/idle FSM driving one of three 10-bit LED patterns,
// advanced by a speed-selectable prescaler tick.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter logic [31:0] CLK_DIV_BASE    = 32'h000FFFFF,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic       sw_stop,
    input  logic [1:0] speed_sel,
    output logic [9:0] led_out,
    output logic [1:0] state_out,
    output logic       tick
);

    logic        run_press;
    logic        mode_press;
    logic [1:0]  stop_ff;
    logic        stop_s;
    state_t      state;
    pattern_t    pattern;
    pattern_t    pat_eff;
    dir_t        dir;
    dir_t        dir_adv;
    logic [31:0] presc;
    logic [31:0] limit;
    logic [9:0]  led_adv;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            stop_ff <= '0;
        else
            stop_ff <= {stop_ff[0], sw_stop};
    end

    assign stop_s    = stop_ff[1];
    assign limit     = CLK_DIV_BASE >> {speed_sel, 1'b0};
    assign pat_eff   = mode_press ? next_pattern(pattern) : pattern;
    assign state_out = state;

    always_comb begin
        led_adv = led_out;
        dir_adv = dir;
        case (pattern)
            PAT_COUNT:  led_adv = led_out + 10'd1;
            PAT_ROTATE: led_adv = {led_out[8:0], led_out[9]};
            PAT_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    led_adv = {led_out[8:0], 1'b0};
                    if (led_adv[9])
                        dir_adv = DIR_RIGHT;
                end else begin
                    led_adv = {1'b0, led_out[9:1]};
                    if (led_adv[0])
                        dir_adv = DIR_LEFT;
                end
            end
            default: ;
        endcase
    end

    // A run press in RUN freezes the prescaler on that same cycle; a mode
    // press reloads the new pattern even when it coincides with a run press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pattern <= PAT_COUNT;
            dir     <= DIR_LEFT;
            led_out <= '0;
            presc   <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (mode_press)
                pattern <= next_pattern(pattern);
            if (stop_s) begin
                state   <= ST_IDLE;
                led_out <= '0;
                presc   <= '0;
                dir     <= DIR_LEFT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_press) begin
                            state   <= ST_RUN;
                            led_out <= pattern_start(pat_eff);
                            presc   <= '0;
                            dir     <= DIR_LEFT;
                        end
                    end
                    ST_RUN: begin
                        if (run_press)
                            state <= ST_PAUSE;
                        if (mode_press) begin
                            led_out <= pattern_start(pat_eff);
                            presc   <= '0;
                            dir     <= DIR_LEFT;
                        end else if (!run_press) begin
                            if (presc >= limit) begin
                                tick    <= 1'b1;
                                presc   <= '0;
                                led_out <= led_adv;
                                dir     <= dir_adv;
                            end else begin
                                presc <= presc + 32'd1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (run_press)
                            state <= ST_RUN;
                        if (mode_press) begin
                            led_out <= pattern_start(pat_eff);
                            presc   <= '0;
                            dir     <= DIR_LEFT;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        led_out <= '0;
                        presc   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected state changes
// and tick values, a negedge monitor pops and compares them.
module tb_led_seq_ctrl;

    typedef struct {
        logic [9:0] led;
        int         gap;
    } tick_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_run = 1'b1;
    logic       btn_mode = 1'b1;
    logic       sw_stop = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic [9:0] led_out;
    logic [1:0] state_out;
    logic       tick;

    int checks = 0;
    int errors = 0;

    logic [1:0] sq[$];
    tick_exp_t  tq[$];
    bit         mon_en = 1'b0;
    bit         watch_ticks = 1'b0;
    int         cyc = 0;
    int         last_evt = 0;
    logic [1:0] prev_state;
    logic [9:0] prev_led;
    logic [9:0] frozen;

    led_seq_ctrl #(
        .CLK_DIV_BASE   (32'd15),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_mode (btn_mode),
        .sw_stop  (sw_stop),
        .speed_sel(speed_sel),
        .led_out  (led_out),
        .state_out(state_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit        evt;
            logic [1:0] es;
            tick_exp_t et;
            evt = 1'b0;
            cyc++;
            if (state_out !== prev_state) begin
                evt = 1'b1;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL state_change: got %0d expected no change", state_out);
                end else begin
                    es = sq.pop_front();
                    chk("state_out", {30'd0, state_out}, {30'd0, es});
                end
                prev_state = state_out;
            end
            if (tick === 1'b1 && watch_ticks) begin
                if (tq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick: got unexpected tick led %0h expected none", led_out);
                end else begin
                    et = tq.pop_front();
                    chk("tick_led", {22'd0, led_out}, {22'd0, et.led});
                    if (et.gap != 0)
                        chk("tick_gap", cyc - last_evt, et.gap);
                end
            end
            if (tick === 1'b1 || led_out !== prev_led)
                evt = 1'b1;
            prev_led = led_out;
            if (evt)
                last_evt = cyc;
        end
    end

    task automatic press(input bit is_mode, input int n);
        @(negedge clk);
        if (is_mode) btn_mode = 1'b0; else btn_run = 1'b0;
        repeat (n) @(negedge clk);
        if (is_mode) btn_mode = 1'b1; else btn_run = 1'b1;
    endtask

    task automatic drain_states(input string name);
        int n = 0;
        while (sq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout with %0d states pending expected 0", name, sq.size());
            sq.delete();
        end
    endtask

    task automatic drain_ticks(input string name);
        int n = 0;
        while (tq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (tq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout with %0d ticks pending expected 0", name, tq.size());
            tq.delete();
        end
    endtask

    task automatic push_tick(input logic [9:0] led, input int gap);
        tick_exp_t t;
        t.led = led;
        t.gap = gap;
        tq.push_back(t);
    endtask

    initial begin
        logic [9:0] v;

        repeat (3) @(negedge clk);
        chk("reset_state", {30'd0, state_out}, 32'd0);
        chk("reset_led", {22'd0, led_out}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        prev_state = state_out;
        prev_led   = led_out;
        mon_en     = 1'b1;
        repeat (5) @(negedge clk);

        // Run from IDLE, pattern 0, speed 0: ticks every 16 cycles
        sq.push_back(2'd1);
        push_tick(10'h001, 16);
        push_tick(10'h002, 16);
        watch_ticks = 1'b1;
        press(1'b0, 10);
        drain_states("run_from_idle");
        drain_ticks("count_ticks");
        watch_ticks = 1'b0;
        repeat (10) @(negedge clk);

        // 3-cycle glitch ignored, 10-cycle press pauses and freezes led_out
        press(1'b0, 3);
        repeat (20) @(negedge clk);
        chk("glitch_state", {30'd0, state_out}, 32'd1);
        sq.push_back(2'd2);
        press(1'b0, 10);
        drain_states("pause");
        watch_ticks = 1'b1;
        @(negedge clk);
        frozen = led_out;
        repeat (40) @(negedge clk);
        chk("pause_led_frozen", {22'd0, led_out}, {22'd0, frozen});
        chk("pause_state", {30'd0, state_out}, 32'd2);
        watch_ticks = 1'b0;

        // Resume, then sw_stop forces IDLE and blocks run presses
        sq.push_back(2'd1);
        press(1'b0, 10);
        drain_states("resume");
        repeat (10) @(negedge clk);
        sq.push_back(2'd0);
        sw_stop = 1'b1;
        drain_states("stop");
        @(negedge clk);
        chk("stop_led", {22'd0, led_out}, 32'd0);
        press(1'b0, 10);
        repeat (20) @(negedge clk);
        chk("stop_run_ignored", {30'd0, state_out}, 32'd0);
        chk("stop_led_held", {22'd0, led_out}, 32'd0);
        sw_stop = 1'b0;
        repeat (5) @(negedge clk);

        // Mode press in RUN at led_out=5 reloads pattern 1 with cleared prescaler
        sq.push_back(2'd1);
        for (int i = 1; i <= 5; i++)
            push_tick(10'(i), 16);
        watch_ticks = 1'b1;
        press(1'b0, 10);
        drain_states("run_again");
        drain_ticks("count_to_5");
        push_tick(10'h002, 16);
        push_tick(10'h004, 16);
        @(negedge clk);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        chk("mode_reload_led", {22'd0, led_out}, 32'h001);
        btn_mode = 1'b1;
        drain_ticks("rotate_ticks");
        watch_ticks = 1'b0;

        // Pattern 2 at speed 3: one-hot bounce ticking every cycle
        sq.push_back(2'd0);
        sw_stop = 1'b1;
        drain_states("stop2");
        press(1'b1, 10);
        repeat (10) @(negedge clk);
        chk("idle_mode_led", {22'd0, led_out}, 32'd0);
        chk("idle_mode_state", {30'd0, state_out}, 32'd0);
        sw_stop = 1'b0;
        speed_sel = 2'd3;
        repeat (5) @(negedge clk);
        sq.push_back(2'd1);
        v = 10'h001;
        for (int i = 0; i < 9; i++) begin
            v = {v[8:0], 1'b0};
            push_tick(v, 1);
        end
        for (int i = 0; i < 9; i++) begin
            v = {1'b0, v[9:1]};
            push_tick(v, 1);
        end
        push_tick(10'h002, 1);
        watch_ticks = 1'b1;
        press(1'b0, 10);
        drain_states("bounce_run");
        drain_ticks("bounce_ticks");
        watch_ticks = 1'b0;

        // Reset mid-RUN with btn_run held low: no RUN until release and re-press
        speed_sel = 2'd0;
        sq.push_back(2'd0);
        @(negedge clk);
        btn_run = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_reset_led", {22'd0, led_out}, 32'd0);
        chk("midrun_reset_tick", {31'd0, tick}, 32'd0);
        reset = 1'b1;
        drain_states("reset_idle");
        repeat (30) @(negedge clk);
        chk("held_btn_no_run", {30'd0, state_out}, 32'd0);
        btn_run = 1'b1;
        repeat (15) @(negedge clk);
        chk("release_no_run", {30'd0, state_out}, 32'd0);
        sq.push_back(2'd1);
        press(1'b0, 10);
        drain_states("repress_run");
        @(negedge clk);
        chk("repress_led_pattern0", {22'd0, led_out}, 32'd0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_BASE, default 32'h000FFFFF, meaning the prescaler terminal count at the slowest speed.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning the number of consecutive stable cycles needed to accept a button level.
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port btn_run, input, 1 bit: asynchronous pushbutton, active-low (pressed = 0).
REQ-006 SHALL have port btn_mode, input, 1 bit: asynchronous pushbutton, active-low.
REQ-007 SHALL have port sw_stop, input, 1 bit: asynchronous level switch; 1 forces IDLE.
REQ-008 SHALL have port speed_sel, input, 2 bits: speed level, where 0 is slowest and 3 is fastest.
REQ-009 SHALL have port led_out, output, 10 bits: registered LED pattern.
REQ-010 SHALL have port state_out, output, 2 bits: FSM state, encoded IDLE=0, RUN=1, PAUSE=2.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse on each pattern advance.

Function
REQ-012 SHALL pass btn_run, btn_mode and sw_stop each through a 2-FF synchronizer before any use.
REQ-013 SHALL debounce each button as follows: the debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 SHALL generate a one-cycle press event when a debounced level goes 1->0; a release generates no event, and a held button generates exactly one event.
REQ-015 SHALL act on a press within DEBOUNCE_CYCLES+4 cycles of a stable raw edge.
REQ-016 SHALL implement these FSM transitions: IDLE + run press -> RUN; RUN + run press -> PAUSE; PAUSE + run press -> RUN; synchronized sw_stop=1 -> IDLE from any state, with priority over run press; IDLE is held while sw_stop=1.
REQ-017 SHALL keep led_out=0, the prescaler at 0 and tick=0 while in IDLE.
REQ-018 SHALL load led_out with the start value of the current pattern on IDLE->RUN: 10'h000 for pattern 0, 10'h001 for patterns 1 and 2.
REQ-019 SHALL run the prescaler only in RUN and freeze its count and led_out in PAUSE; PAUSE->RUN resumes from the frozen count.
REQ-020 SHALL use prescaler limit = CLK_DIV_BASE >> (2*speed_sel): in RUN, if count >= limit then tick=1 and count<=0, else count<=count+1; period = limit+1 cycles.
REQ-021 SHALL handle a mid-count speed_sel change by the >= compare: if count already exceeds the new limit, tick fires on the next cycle.
REQ-022 SHALL maintain a pattern register with values 0, 1, 2; each mode press cycles it 0->1->2->0 in any state.
REQ-023 SHALL, on a mode press in RUN or PAUSE, load the new pattern's start value, clear the prescaler and set direction to left; in IDLE a mode press changes only the pattern register.
REQ-024 SHALL advance on each tick as follows: pattern 0 does led_out+1 with wrap 10'h3FF->10'h000; pattern 1 rotates left with bit9->bit0; pattern 2 bounces a single one-hot bit, moving left until bit9 then right until bit0, reversing direction on the same tick it reaches an end.
REQ-025 SHALL apply both a same-cycle run press and mode press; the pattern reload takes effect and the state transition occurs.
REQ-026 SHALL hold led_out as one-hot at all times in patterns 1 and 2 outside IDLE.

Reset
REQ-027 SHALL, when reset=0 at a clk edge, set state=IDLE, pattern=0, direction=left, led_out=0, tick=0, prescaler=0, and debounced levels=1 (released), and clear the debounce counters.
REQ-028 SHALL, on reset during RUN or PAUSE, abandon the run; the first action after reset release requires a new run press.
REQ-029 SHALL NOT generate a press event from a button held low through reset release until that button is released and pressed again.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/PAUSE), the pattern codes, and the pattern start-value constants in a shared package led_pkg.
REQ-031 SHALL implement synchronizer, debounce and falling-edge detection as one sub-module, btn_debounce, instantiated twice; sw_stop uses only the synchronizer.

Verification
REQ-032 SHALL verify, with CLK_DIV_BASE=15, DEBOUNCE_CYCLES=4, speed_sel=0, that a run press from IDLE gives state_out=1 and led_out 0->1->2 at 16-cycle tick spacing.
REQ-033 SHALL verify that a 3-cycle low glitch on btn_run produces no state change, and that a 10-cycle low produces exactly one RUN->PAUSE with led_out frozen.
REQ-034 SHALL verify, with pattern 2 and speed_sel=3 (limit 0), that led_out goes 001,002,...,200,100,...,001,002, ticking every cycle.
REQ-035 SHALL verify that a mode press in RUN at pattern 0 with led_out=5 gives pattern 1, led_out=10'h001, and prescaler cleared.
REQ-036 SHALL verify that sw_stop=1 in RUN gives state_out=0 and led_out=0, and that a run press while sw_stop=1 is ignored.
REQ-037 SHALL verify that reset asserted mid-RUN with btn_run held low gives IDLE with no RUN until release and re-press.
